// File: rtl/cache_controller_pkg.sv
// Shared constants, FSM encoding and address helpers for the direct-mapped cache.
// The index is the address modulo the line count; the tag is everything above the index.
package cache_controller_pkg;

    localparam int ADDR_W  = 13;
    localparam int DATA_W  = 13;
    localparam int LINES   = 8;
    localparam int INDEX_W = 3;
    localparam int TAG_W   = ADDR_W - INDEX_W;
    localparam int CNT_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        WRITE_MEM,
        RESPOND,
        RELEASE
    } state_t;

    function automatic logic [INDEX_W-1:0] modulo(input logic [ADDR_W-1:0] addr);
        logic [ADDR_W-1:0] rem;
        rem = addr % ADDR_W'(LINES);
        return rem[INDEX_W-1:0];
    endfunction

    function automatic logic [TAG_W-1:0] getTag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1:INDEX_W];
    endfunction

endpackage

// File: rtl/cache_controller_line_array.sv
// Valid/tag/data storage for the cache: combinational read port, one synchronous write port.
// Only the valid bits are reset; stale tag/data behind a cleared valid bit is harmless.
module cache_line_array
    import cache_controller_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [INDEX_W-1:0] rdIndex_i,
    output logic               rdValid_o,
    output logic [TAG_W-1:0]   rdTag_o,
    output logic [DATA_W-1:0]  rdData_o,
    input  logic               wrEn_i,
    input  logic [INDEX_W-1:0] wrIndex_i,
    input  logic [TAG_W-1:0]   wrTag_i,
    input  logic [DATA_W-1:0]  wrData_i
);

    logic [LINES-1:0]  valid_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [DATA_W-1:0] data_q [LINES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
        end else if (wrEn_i) begin
            valid_q[wrIndex_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn_i) begin
            tag_q[wrIndex_i]  <= wrTag_i;
            data_q[wrIndex_i] <= wrData_i;
        end
    end

    assign rdValid_o = valid_q[rdIndex_i];
    assign rdTag_o   = tag_q[rdIndex_i];
    assign rdData_o  = data_q[rdIndex_i];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped write-through, write-allocate cache between the CPU and Main_Memory.
// Requests are latched in IDLE; RELEASE waits for the CPU to drop its request so it is served once.
module cache_controller
    import cache_controller_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_dataIn,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic              cpu_instruction,
    output logic [DATA_W-1:0] cpu_dataOut,
    output logic              cpu_done,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_dataIn,
    input  logic [DATA_W-1:0] mem_dataOut,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_instruction,
    input  logic              mem_done,
    output logic [CNT_W-1:0]  hit_count,
    output logic [CNT_W-1:0]  miss_count
);

    state_t            state_q;
    logic [ADDR_W-1:0] reqAddr_q;
    logic [DATA_W-1:0] reqData_q;
    logic              reqInstr_q;
    logic              memRead_q;
    logic              memWrite_q;
    logic              cpuDone_q;
    logic [DATA_W-1:0] cpuData_q;
    logic [CNT_W-1:0]  hitCnt_q;
    logic [CNT_W-1:0]  missCnt_q;

    logic              rdValid;
    logic [TAG_W-1:0]  rdTag;
    logic [DATA_W-1:0] rdData;
    logic              lookupHit;
    logic              wrEn;
    logic [DATA_W-1:0] wrData;

    // Lookup uses the live CPU address because the hit decision is made at the sampling edge.
    assign lookupHit = rdValid && (rdTag == getTag(cpu_address));
    assign wrEn      = mem_done && ((state_q == FILL) || (state_q == WRITE_MEM));
    assign wrData    = (state_q == FILL) ? mem_dataOut : reqData_q;

    cache_line_array u_lines (
        .clk       (clk),
        .reset     (reset),
        .rdIndex_i (modulo(cpu_address)),
        .rdValid_o (rdValid),
        .rdTag_o   (rdTag),
        .rdData_o  (rdData),
        .wrEn_i    (wrEn),
        .wrIndex_i (modulo(reqAddr_q)),
        .wrTag_i   (getTag(reqAddr_q)),
        .wrData_i  (wrData)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            reqAddr_q  <= '0;
            reqData_q  <= '0;
            reqInstr_q <= 1'b0;
            memRead_q  <= 1'b0;
            memWrite_q <= 1'b0;
            cpuDone_q  <= 1'b0;
            cpuData_q  <= '0;
            hitCnt_q   <= '0;
            missCnt_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cpu_read || cpu_write) begin
                        reqAddr_q  <= cpu_address;
                        reqData_q  <= cpu_dataIn;
                        reqInstr_q <= cpu_instruction;
                        if (lookupHit) begin
                            if (hitCnt_q != {CNT_W{1'b1}}) hitCnt_q <= hitCnt_q + 1'b1;
                        end else begin
                            if (missCnt_q != {CNT_W{1'b1}}) missCnt_q <= missCnt_q + 1'b1;
                        end
                        // A simultaneous read and write is treated as a write.
                        if (cpu_write) begin
                            memWrite_q <= 1'b1;
                            state_q    <= WRITE_MEM;
                        end else if (lookupHit) begin
                            cpuData_q <= rdData;
                            cpuDone_q <= 1'b1;
                            state_q   <= RESPOND;
                        end else begin
                            memRead_q <= 1'b1;
                            state_q   <= FILL;
                        end
                    end
                end
                FILL: begin
                    if (mem_done) begin
                        memRead_q <= 1'b0;
                        cpuData_q <= mem_dataOut;
                        cpuDone_q <= 1'b1;
                        state_q   <= RESPOND;
                    end
                end
                WRITE_MEM: begin
                    if (mem_done) begin
                        memWrite_q <= 1'b0;
                        cpuDone_q  <= 1'b1;
                        state_q    <= RESPOND;
                    end
                end
                RESPOND: begin
                    cpuDone_q <= 1'b0;
                    state_q   <= RELEASE;
                end
                RELEASE: begin
                    if (!cpu_read && !cpu_write) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cpu_dataOut     = cpuData_q;
    assign cpu_done        = cpuDone_q;
    assign mem_address     = reqAddr_q;
    assign mem_dataIn      = reqData_q;
    assign mem_read        = memRead_q;
    assign mem_write       = memWrite_q;
    assign mem_instruction = reqInstr_q;
    assign hit_count       = hitCnt_q;
    assign miss_count      = missCnt_q;

endmodule

// File: tb/tb_cache_controller.sv
// Scoreboard bench for cache_controller: expected read data is queued per request
// and a negedge monitor checks it whenever cpu_done pulses; a small memory model answers mem_*.
module tb_cache_controller;

    logic        clk;
    logic        reset;
    logic [12:0] cpu_address;
    logic [12:0] cpu_dataIn;
    logic        cpu_read;
    logic        cpu_write;
    logic        cpu_instruction;
    logic [12:0] cpu_dataOut;
    logic        cpu_done;
    logic [12:0] mem_address;
    logic [12:0] mem_dataIn;
    logic [12:0] mem_dataOut;
    logic        mem_read;
    logic        mem_write;
    logic        mem_instruction;
    logic        mem_done;
    logic [7:0]  hit_count;
    logic [7:0]  miss_count;

    int total = 0;
    int bad   = 0;

    logic [12:0] expQ[$];
    int          doneCount = 0;

    logic [12:0] memModel [8192];
    int          respDelay = 2;
    int          memReads  = 0;
    int          memWrites = 0;
    logic [12:0] lastRdAddr;
    logic [12:0] lastWrAddr;
    logic [12:0] lastWrData;

    logic        snapDone, snapRead, snapWrite, snapInstr;
    logic [12:0] snapAddr;

    cache_controller dut (
        .clk             (clk),
        .reset           (reset),
        .cpu_address     (cpu_address),
        .cpu_dataIn      (cpu_dataIn),
        .cpu_read        (cpu_read),
        .cpu_write       (cpu_write),
        .cpu_instruction (cpu_instruction),
        .cpu_dataOut     (cpu_dataOut),
        .cpu_done        (cpu_done),
        .mem_address     (mem_address),
        .mem_dataIn      (mem_dataIn),
        .mem_dataOut     (mem_dataOut),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_instruction (mem_instruction),
        .mem_done        (mem_done),
        .hit_count       (hit_count),
        .miss_count      (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Main_Memory model: answers a read or write after respDelay negedges with a one-cycle Done.
    initial begin
        int waitCnt;
        waitCnt     = 0;
        mem_done    = 1'b0;
        mem_dataOut = '0;
        forever begin
            @(negedge clk);
            if (mem_done) begin
                mem_done = 1'b0;
                waitCnt  = 0;
            end else if (mem_read || mem_write) begin
                waitCnt++;
                if (waitCnt >= respDelay) begin
                    if (mem_write) begin
                        memModel[mem_address] = mem_dataIn;
                        lastWrAddr = mem_address;
                        lastWrData = mem_dataIn;
                        memWrites++;
                    end else begin
                        mem_dataOut = memModel[mem_address];
                        lastRdAddr  = mem_address;
                        memReads++;
                    end
                    mem_done = 1'b1;
                end
            end else begin
                waitCnt = 0;
            end
        end
    end

    // Monitor: every cpu_done pulse consumes one queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (cpu_done) begin
                doneCount++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpectedDone", 32'd1, 32'd0);
                end else begin
                    checkOutput("cpuDataOut", 32'(cpu_dataOut), 32'(expQ.pop_front()));
                end
            end
        end
    end

    task automatic applyStimulus(input logic [12:0] addr, input logic [12:0] data,
                                 input logic rd, input logic wr, input logic instr,
                                 input logic [12:0] expData, input int holdCycles);
        int startDone;
        int budget;
        @(negedge clk);
        expQ.push_back(expData);
        startDone       = doneCount;
        cpu_address     = addr;
        cpu_dataIn      = data;
        cpu_read        = rd;
        cpu_write       = wr;
        cpu_instruction = instr;
        @(posedge clk);
        @(negedge clk);
        #1;
        snapDone  = cpu_done;
        snapRead  = mem_read;
        snapWrite = mem_write;
        snapInstr = mem_instruction;
        snapAddr  = mem_address;
        budget = 0;
        while (doneCount == startDone && budget < 100) begin
            @(posedge clk);
            budget++;
        end
        repeat (holdCycles) @(posedge clk);
        @(negedge clk);
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        repeat (2) @(posedge clk);
        checkOutput("donePulses", 32'(doneCount - startDone), 32'd1);
    endtask

    initial begin
        int readsBefore;
        for (int i = 0; i < 8192; i++) memModel[i] = '0;
        memModel[13'h005] = 13'h0F0;
        memModel[13'h015] = 13'h123;
        memModel[13'h007] = 13'h0AA;

        reset           = 1'b1;
        cpu_address     = '0;
        cpu_dataIn      = '0;
        cpu_read        = 1'b0;
        cpu_write       = 1'b0;
        cpu_instruction = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstCpuDone",  32'(cpu_done), 32'd0);
        checkOutput("rstDataOut",  32'(cpu_dataOut), 32'd0);
        checkOutput("rstMemRead",  32'(mem_read), 32'd0);
        checkOutput("rstMemWrite", 32'(mem_write), 32'd0);
        checkOutput("rstMemAddr",  32'(mem_address), 32'd0);
        checkOutput("rstHits",     32'(hit_count), 32'd0);
        checkOutput("rstMisses",   32'(miss_count), 32'd0);
        reset = 1'b0;

        // Cold read miss of 0x005
        applyStimulus(13'h005, 13'h000, 1'b1, 1'b0, 1'b0, 13'h0F0, 0);
        checkOutput("missMemRead", 32'(snapRead), 32'd1);
        checkOutput("missMemAddr", 32'(snapAddr), 32'h005);
        checkOutput("missRdAddr",  32'(lastRdAddr), 32'h005);
        checkOutput("missReads",   32'(memReads), 32'd1);
        checkOutput("missHits",    32'(hit_count), 32'd0);
        checkOutput("missMisses",  32'(miss_count), 32'd1);

        // Repeat read: hit with one-cycle latency and no memory traffic
        applyStimulus(13'h005, 13'h000, 1'b1, 1'b0, 1'b0, 13'h0F0, 0);
        checkOutput("hitLatency", 32'(snapDone), 32'd1);
        checkOutput("hitMemRead", 32'(snapRead), 32'd0);
        checkOutput("hitReads",   32'(memReads), 32'd1);
        checkOutput("hitHits",    32'(hit_count), 32'd1);

        // Write 0x1A5 to 0x00D (same index, new tag): cpu_dataOut keeps 0x0F0
        applyStimulus(13'h00D, 13'h1A5, 1'b0, 1'b1, 1'b0, 13'h0F0, 0);
        checkOutput("wrMemWrite", 32'(snapWrite), 32'd1);
        checkOutput("wrWrites",   32'(memWrites), 32'd1);
        checkOutput("wrAddr",     32'(lastWrAddr), 32'h00D);
        checkOutput("wrData",     32'(lastWrData), 32'h1A5);
        checkOutput("wrMisses",   32'(miss_count), 32'd2);

        applyStimulus(13'h00D, 13'h000, 1'b1, 1'b0, 1'b0, 13'h1A5, 0);
        checkOutput("allocLatency", 32'(snapDone), 32'd1);
        checkOutput("allocReads",   32'(memReads), 32'd1);
        checkOutput("allocHits",    32'(hit_count), 32'd2);

        applyStimulus(13'h005, 13'h000, 1'b1, 1'b0, 1'b0, 13'h0F0, 0);
        checkOutput("aliasReads",  32'(memReads), 32'd2);
        checkOutput("aliasMisses", 32'(miss_count), 32'd3);

        // Held request: one pulse and one memory access despite 5 extra cycles
        readsBefore = memReads;
        applyStimulus(13'h015, 13'h000, 1'b1, 1'b0, 1'b0, 13'h123, 5);
        checkOutput("holdReads",  32'(memReads - readsBefore), 32'd1);
        checkOutput("holdMisses", 32'(miss_count), 32'd4);

        // Reset during FILL
        respDelay = 20;
        @(negedge clk);
        cpu_address = 13'h007;
        cpu_read    = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("fillMemRead", 32'(mem_read), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rstFillMemRead", 32'(mem_read), 32'd0);
        checkOutput("rstFillHits",    32'(hit_count), 32'd0);
        checkOutput("rstFillMisses",  32'(miss_count), 32'd0);
        @(negedge clk);
        cpu_read = 1'b0;
        @(negedge clk);
        reset     = 1'b0;
        respDelay = 2;
        readsBefore = memReads;
        applyStimulus(13'h007, 13'h000, 1'b1, 1'b0, 1'b0, 13'h0AA, 0);
        checkOutput("postRstMemRead", 32'(snapRead), 32'd1);
        checkOutput("postRstReads",   32'(memReads - readsBefore), 32'd1);
        checkOutput("postRstMisses",  32'(miss_count), 32'd1);
        checkOutput("postRstHits",    32'(hit_count), 32'd0);

        // Read and write together: write wins, instruction flag forwarded
        applyStimulus(13'h003, 13'h055, 1'b1, 1'b1, 1'b1, 13'h0AA, 0);
        checkOutput("bothMemWrite", 32'(snapWrite), 32'd1);
        checkOutput("bothMemRead",  32'(snapRead), 32'd0);
        checkOutput("bothInstr",    32'(snapInstr), 32'd1);
        checkOutput("bothWrites",   32'(memWrites), 32'd2);
        checkOutput("bothWrData",   32'(lastWrData), 32'h055);
        checkOutput("bothMisses",   32'(miss_count), 32'd2);

        // Hit counter saturation
        for (int i = 0; i < 260; i++) begin
            applyStimulus(13'h003, 13'h000, 1'b1, 1'b0, 1'b0, 13'h055, 0);
        end
        checkOutput("satHits",   32'(hit_count), 32'd255);
        checkOutput("satMisses", 32'(miss_count), 32'd2);
        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Direct-mapped, unified instruction/data cache placed between the CPU datapath (fetch and load/store) and Main_Memory.
- Index is address modulo 8, matching the modulo helper; 8 one-word lines of 13 bits.
- Write-through with write-allocate. Every write reaches Main_Memory; reads that hit return without touching memory.
- Hit and miss counters are exposed for the semester performance report.

Parameters:
- ADDR_W, 13, address width.
- DATA_W, 13, word width.
- LINES, 8, number of lines. Index width INDEX_W = 3; tag = address[12:3], 10 bits.
- CNT_W, 8, width of the hit and miss counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- cpu_address  in  13  request address.
- cpu_dataIn  in  13  write data.
- cpu_read  in  1  read request; held until cpu_done.
- cpu_write  in  1  write request; held until cpu_done.
- cpu_instruction  in  1  1 = instruction fetch; forwarded to memory.
- cpu_dataOut  out  13  read data; registered.
- cpu_done  out  1  one-cycle completion pulse.
- mem_address  out  13  to Main_Memory address.
- mem_dataIn  out  13  to Main_Memory dataIn.
- mem_dataOut  in  13  from Main_Memory dataOut.
- mem_read  out  1  to Main_Memory read.
- mem_write  out  1  to Main_Memory write.
- mem_instruction  out  1  to Main_Memory instruction.
- mem_done  in  1  Main_Memory Done.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Clocking and reset: one clock, clk; reset is asynchronous and active-high.
- While reset is asserted:
  - all 8 valid bits clear; tag and data arrays need not be cleared;
  - FSM goes to IDLE;
  - every output is 0, including both counters.
- Reset mid-operation drops mem_read/mem_write immediately. The line being filled is not written.
- FSM states: IDLE, FILL, WRITE_MEM, RESPOND, RELEASE.
- IDLE:
  - Samples the request at the rising edge. If cpu_write and cpu_read are both high, the write wins.
  - Request address, data and instruction flag are latched at this edge. The mem_* outputs drive from the latched copies.
- Read hit (valid[idx] and tag match):
  - cpu_dataOut gets the line data; hit_count increments; next state RESPOND.
  - cpu_done is high in the cycle after the sampling edge, so latency is 1 cycle.
- Read miss:
  - next state FILL; miss_count increments.
  - mem_read=1 from the next cycle, with mem_address = latched address and mem_instruction = latched flag.
- FILL:
  - Holds mem_read until mem_done is sampled high.
  - At that edge: the line is written (data = mem_dataOut, tag, valid=1); cpu_dataOut = mem_dataOut; mem_read drops; next state RESPOND.
  - Total latency is memory latency + 2 cycles.
- Write (hit or miss):
  - Next state WRITE_MEM with mem_write=1, mem_dataIn = latched data.
  - Hit versus miss is counted in IDLE by the same tag compare.
- WRITE_MEM:
  - On mem_done: the line is updated with latched data, tag and valid=1 (write-allocate); mem_write drops; next state RESPOND.
  - cpu_dataOut is unchanged.
- RESPOND: cpu_done=1 for exactly one cycle; next state RELEASE.
- RELEASE:
  - Waits until cpu_read and cpu_write are both low, then goes to IDLE.
  - This prevents a held request from being serviced twice.
- Boundary rules:
  - mem_done outside FILL/WRITE_MEM is ignored.
  - Request changes after the sampling edge are ignored until RELEASE.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
  - cpu_dataOut holds its last value between responses.
- Addresses differing only in tag alias to the same line; the newer access replaces the line.
- Instruction and data accesses share the lines. cpu_instruction only affects mem_instruction.

Decomposition:
- Shared package: ADDR_W, DATA_W, INDEX_W, TAG_W constants; FSM state encoding; index/tag extraction via the shared modulo function.
- One natural sub-module, cache_line_array: valid/tag/data storage with a combinational read port and a one-port synchronous write, plus asynchronous clear of the valid bits.

Test Plan:
- Reset, then read 0x005 with mem_dataOut=0x0F0 and Done after 2 cycles:
  - mem_read asserted with mem_address=0x005;
  - cpu_dataOut=0x0F0, one cpu_done pulse;
  - miss_count=1, hit_count=0.
- Repeat the read of 0x005:
  - cpu_done one cycle after sampling, cpu_dataOut=0x0F0;
  - mem_read stays 0; hit_count=1.
- Write 0x1A5 to 0x00D (index 5, tag 1):
  - mem_write with data 0x1A5 until Done;
  - a later read of 0x00D hits, returns 0x1A5 with no memory access;
  - a read of 0x005 now misses.
- Hold cpu_read high for 5 cycles after cpu_done -> exactly one cpu_done pulse and one memory access.
- Assert reset during FILL:
  - mem_read drops the same cycle;
  - a subsequent read of the same address misses; counters are 0.
- Assert cpu_read and cpu_write together on 0x003 -> write path taken (mem_write=1, mem_read=0); mem_instruction follows cpu_instruction=1.
